serial_adder_4bit: RTL and testbench
====================================

SERIAL_ADDER_4BIT -- requirements
Module: serial_adder_4bit

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits; legal range 2..16.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled on rising clk edge while in IDLE.
REQ-005 A  input  WIDTH  addend, captured on the accepted start edge.
REQ-006 B  input  WIDTH  addend, captured on the accepted start edge.
REQ-007 busy  output  1  high while in ADD state.
REQ-008 done  output  1  single-cycle pulse, high while in DONE state.
REQ-009 Sum  output  WIDTH  registered result (A+B) mod 2^WIDTH.
REQ-010 Cout  output  1  registered carry out of bit WIDTH-1.
REQ-011 Ovf  output  1  signed overflow flag; present only with SERIAL_ADD_OVF_EN (REQ-029).

Function
REQ-012 FSM SHALL have exactly three states: IDLE, ADD, DONE.
REQ-013 IDLE: start=1 at edge T0 SHALL load A and B into shift registers, clear the carry flop and the bit counter, and move to ADD.
REQ-014 ADD: each edge SHALL compute one bit from LSB upward with a single full adder: s = a_sr[0]^b_sr[0]^c; c_next = majority(a_sr[0], b_sr[0], c).
REQ-015 Each ADD edge SHALL shift s into the MSB of an internal result shift register, shift both operand registers right by one bit, and increment the counter.
REQ-016 On edge T(WIDTH), counter = WIDTH-1, SHALL copy the completed result to Sum and the final carry to Cout, and move to DONE.
REQ-017 Latency: done SHALL be high in the cycle after edge T(WIDTH), i.e. WIDTH cycles after the accepted start edge.
REQ-018 DONE SHALL last exactly one cycle, then move to IDLE unconditionally.
REQ-019 start SHALL be ignored in ADD and in DONE; no queuing; A and B changes during ADD SHALL NOT affect the result.
REQ-020 Sum, Cout (and Ovf) SHALL change only on the REQ-016 edge and SHALL hold until the next completion.
REQ-021 busy and done SHALL never be high together; both SHALL be low in IDLE.
REQ-022 Back-to-back: start held high continuously SHALL yield one accepted operation per WIDTH+2 cycles.
REQ-023 Carry wrap: a carry out of the MSB SHALL appear only on Cout; Sum SHALL wrap modulo 2^WIDTH.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, Sum=0, Cout=0 and Ovf=0, without waiting for a clock edge.
REQ-025 rst_n=0 SHALL clear the operand and result shift registers, the carry flop and the counter.
REQ-026 Reset asserted during ADD SHALL abort the operation; the partial result SHALL never reach Sum.
REQ-027 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-028 Macro SERIAL_ADD_OVF_EN SHALL control the signed-overflow feature.
REQ-029 Defined: port Ovf exists; on the REQ-016 edge Ovf = (carry into MSB) XOR (carry out of MSB); requires one extra flop holding the previous carry.
REQ-030 Undefined: port Ovf and its flop SHALL be absent; all other behaviour is identical.

Verification
REQ-031 WIDTH=4, A=3, B=4, start pulse -> done high 4 cycles after the start edge, Sum=7, Cout=0, busy high for exactly 4 cycles.
REQ-032 A=9, B=8 -> Sum=1, Cout=1; A=15, B=1 -> Sum=0, Cout=1; Sum and Cout then held through 10 idle cycles.
REQ-033 Second start pulse with A=1, B=1 two cycles into an A=2, B=2 operation -> ignored; Sum=4 and only one done pulse.
REQ-034 rst_n low for 1 cycle at the 2nd ADD cycle of A=5, B=5 -> busy=0, done=0, Sum=0 asynchronously; no done pulse; new start A=1, B=2 -> Sum=3.
REQ-035 With SERIAL_ADD_OVF_EN: A=7, B=1 -> Sum=8, Cout=0, Ovf=1; A=8, B=8 -> Sum=0, Cout=1, Ovf=1; A=2, B=3 -> Ovf=0.
REQ-036 start held high for 20 cycles with A=6, B=5 -> done pulses every 6 cycles, Sum=11 each time.

Source files
------------

// File: rtl/serial_adder_4bit.sv
// serial_adder_4bit: bit-serial adder built from one full adder.
// Operands are loaded on an accepted start, summed LSB first over WIDTH
// cycles, and the result is published on Sum/Cout with a one-cycle done.
// Optional macro SERIAL_ADD_OVF_EN adds a registered signed-overflow flag, Ovf.
module serial_adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             Ovf,
`endif
    output logic             Cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_s;
    logic             w_cnext;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    // Single full adder on the operand LSBs plus the running carry.
    always_comb begin
        w_s        = r_a[0] ^ r_b[0] ^ r_carry;
        w_cnext    = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
        w_last     = (r_cnt == CW'(WIDTH - 1));
        w_res_next = {w_s, r_res[WIDTH-1:1]};
    end

    // Control FSM and datapath; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            Sum     <= '0;
            Cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            Ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_res   <= '0;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_res   <= w_res_next;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_cnext;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        // r_carry is the carry into the MSB, w_cnext the carry out.
                        Sum     <= w_res_next;
                        Cout    <= w_cnext;
`ifdef SERIAL_ADD_OVF_EN
                        Ovf     <= r_carry ^ w_cnext;
`endif
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // One-cycle result strobe; start is ignored here.
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_4bit.sv
// Testbench for serial_adder_4bit (WIDTH=4): table vectors, corner-case
// sequences and random operations against an arithmetic reference model.
module tb_serial_adder_4bit;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         Ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    serial_adder_4bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
`ifdef SERIAL_ADD_OVF_EN
        .Ovf   (Ovf),
`endif
        .Cout  (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on unsigned and signed views.
    function automatic void model(input int a, input int b,
                                  output int s, output int c, output int o);
        int sa, sb, ss;
        s  = (a + b) % (1 << W);
        c  = (a + b) >= (1 << W) ? 1 : 0;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        ss = sa + sb;
        o  = (ss > (1 << (W - 1)) - 1 || ss < -(1 << (W - 1))) ? 1 : 0;
    endfunction

    // One operation: start pulse, latency/busy checks, result checks.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int es, input int ec, input int eo, input string tag);
        int lat, bcnt, both, seen;
        @(negedge clk);
        start = 1'b1; A = a; B = b;
        @(posedge clk);
        #1 start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        lat = 0; bcnt = 0; both = 0; seen = 0;
        for (int k = 1; k <= 4 * W; k++) begin
            @(negedge clk);
            if (busy && done) both++;
            if (done) begin
                lat  = k - 1;
                seen = 1;
                break;
            end
            if (busy) bcnt++;
        end
        chk({tag, " done_seen"}, seen, 1);
        chk({tag, " latency"}, lat, W);
        chk({tag, " busy_cycles"}, bcnt, W);
        chk({tag, " busy_and_done"}, both, 0);
        chk({tag, " Sum"}, int'(Sum), es);
        chk({tag, " Cout"}, int'(Cout), ec);
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, " Ovf"}, int'(Ovf), eo);
`else
        if (eo < 0) $display("note: negative ovf expectation");
`endif
        @(negedge clk);
        chk({tag, " done_one_cycle"}, int'(done), 0);
    endtask

    vec_t tbl[7];

    initial begin
        int es, ec, eo, npulse, last_cyc, a_i, b_i;
        tbl[0] = '{a: 4'd3,  b: 4'd4,  s: 4'd7,  c: 1'b0, o: 1'b0};
        tbl[1] = '{a: 4'd9,  b: 4'd8,  s: 4'd1,  c: 1'b1, o: 1'b1};
        tbl[2] = '{a: 4'd15, b: 4'd1,  s: 4'd0,  c: 1'b1, o: 1'b0};
        tbl[3] = '{a: 4'd7,  b: 4'd1,  s: 4'd8,  c: 1'b0, o: 1'b1};
        tbl[4] = '{a: 4'd8,  b: 4'd8,  s: 4'd0,  c: 1'b1, o: 1'b1};
        tbl[5] = '{a: 4'd2,  b: 4'd3,  s: 4'd5,  c: 1'b0, o: 1'b0};
        tbl[6] = '{a: 4'd15, b: 4'd15, s: 4'd14, c: 1'b1, o: 1'b0};

        // Reset state, checked before any clock edge.
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
        #2;
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst Sum", int'(Sum), 0);
        chk("rst Cout", int'(Cout), 0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst Ovf", int'(Ovf), 0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Table vectors.
        for (int i = 0; i < 7; i++)
            run_op(tbl[i].a, tbl[i].b, int'(tbl[i].s), int'(tbl[i].c),
                   int'(tbl[i].o), $sformatf("vec%0d", i));

        // Result hold: 15+1 then 10 idle cycles with wiggling inputs.
        run_op(4'd15, 4'd1, 0, 1, 0, "wrap");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            A = W'($urandom); B = W'($urandom);
        end
        chk("hold Sum", int'(Sum), 0);
        chk("hold Cout", int'(Cout), 1);

        // Start during ADD is ignored: 2+2 with a 1+1 pulse two cycles in.
        @(negedge clk);
        start = 1'b1; A = 4'd2; B = 4'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; A = 4'd1; B = 4'd1;
        @(negedge clk);
        start = 1'b0;
        npulse = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (done) npulse++;
        end
        chk("ignore done_pulses", npulse, 1);
        chk("ignore Sum", int'(Sum), 4);

        // Async reset in the 2nd ADD cycle of 5+5 (Sum is 4 beforehand).
        @(negedge clk);
        start = 1'b1; A = 4'd5; B = 4'd5;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort Sum", int'(Sum), 0);
        chk("abort Cout", int'(Cout), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        npulse = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) npulse++;
        end
        chk("abort no_done", npulse, 0);
        chk("abort Sum_after", int'(Sum), 0);
        run_op(4'd1, 4'd2, 3, 0, 0, "post_rst");

        // Back-to-back: start held 20 cycles with 6+5.
        @(negedge clk);
        start = 1'b1; A = 4'd6; B = 4'd5;
        npulse = 0; last_cyc = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                if (npulse > 0) chk("b2b spacing", cyc - last_cyc, W + 2);
                chk("b2b Sum", int'(Sum), 11);
                last_cyc = cyc;
                npulse++;
            end
        end
        start = 1'b0;
        chk("b2b pulses", npulse, 3);
        repeat (2 * W) @(negedge clk);

        // Random operations against the model.
        for (int i = 0; i < 40; i++) begin
            a_i = int'($urandom_range(0, (1 << W) - 1));
            b_i = int'($urandom_range(0, (1 << W) - 1));
            model(a_i, b_i, es, ec, eo);
            run_op(W'(a_i), W'(b_i), es, ec, eo, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
